// File: rtl/phy_pkg.sv
// Shared types and default sizing for the PHY burst scheduler.
package phy_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int BLOCK_BITS_DEF    = 192;
    localparam int SYM_PER_BLOCK_DEF = 96;
    localparam int GAP_CYC_DEF       = 4;
    localparam int TIMEOUT_CYC_DEF   = 255;

endpackage

// File: rtl/phy_burst_sched_if.sv
// Bit stream from the interleaver, bit stream to the modulator, and the symbol strobe back.
interface phy_burst_sched_if;

    logic up_valid;
    logic up_data;
    logic up_ready;
    logic mod_valid_in;
    logic mod_data_in;
    logic mod_ready_in;
    logic sym_valid;

    modport master (
        output up_valid, up_data, mod_ready_in, sym_valid,
        input  up_ready, mod_valid_in, mod_data_in
    );

    modport slave (
        input  up_valid, up_data, mod_ready_in, sym_valid,
        output up_ready, mod_valid_in, mod_data_in
    );

endinterface

// File: rtl/burst_counter.sv
// Up-counter with synchronous clear (priority over increment) and a terminal-count flag.
module burst_counter #(
    parameter int W    = 8,
    parameter int TERM = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (rst)      cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == W'(TERM));

endmodule

// File: rtl/phy_burst_sched.sv
// Burst scheduler: gates interleaver bits into the modulator block by block, waits for
// each block's symbols to drain, inserts guard gaps and reports block/burst completion.
module phy_burst_sched
    import phy_pkg::*;
#(
    parameter int BLOCK_BITS    = BLOCK_BITS_DEF,
    parameter int SYM_PER_BLOCK = SYM_PER_BLOCK_DEF,
    parameter int GAP_CYC       = GAP_CYC_DEF,
    parameter int TIMEOUT_CYC   = TIMEOUT_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [7:0]         num_blocks,
    phy_burst_sched_if.slave   bus,
    output logic               busy,
    output logic               block_done,
    output logic               burst_done,
    output logic [7:0]         blk_cnt,
    output logic               err
);

    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t          state;
    logic [7:0]      nb_q;
    logic [7:0]      bit_cnt;
    logic [6:0]      sym_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [TW-1:0]   to_cnt;
    logic            bit_tc, sym_tc, gap_tc, to_tc;

    logic in_load, in_drain, xfer, start_acc, blk_fin, to_fire, sym_err;

    assign in_load   = (state == S_LOAD);
    assign in_drain  = (state == S_DRAIN);
    assign start_acc = start && (state == S_IDLE);

    // Abort and reset pull ready low in the same cycle so no bit slips through.
    assign bus.up_ready     = in_load && bus.mod_ready_in && !abort && !rst;
    assign xfer             = bus.up_valid && bus.up_ready;
    assign bus.mod_valid_in = xfer;
    assign bus.mod_data_in  = bus.up_data;

    assign blk_fin = in_drain && sym_tc && !abort;
    assign to_fire = in_drain && !bus.sym_valid && to_tc && !sym_tc && !abort;
    assign sym_err = bus.sym_valid &&
                     ((state == S_IDLE) || (state == S_GAP) || (state == S_DONE));

    burst_counter #(.W(8), .TERM(BLOCK_BITS - 1)) u_bits (
        .clk (clk), .rst (rst),
        .clr (!in_load || (xfer && bit_tc)),
        .inc (xfer),
        .cnt (bit_cnt), .tc (bit_tc)
    );

    // Symbols saturate at the block size; extra strobes are dropped.
    burst_counter #(.W(7), .TERM(SYM_PER_BLOCK)) u_syms (
        .clk (clk), .rst (rst),
        .clr (!(in_load || in_drain) || blk_fin || abort),
        .inc (bus.sym_valid && (in_load || in_drain) && !sym_tc),
        .cnt (sym_cnt), .tc (sym_tc)
    );

    burst_counter #(.W(GW), .TERM(GAP_CYC - 1)) u_gap (
        .clk (clk), .rst (rst),
        .clr ((state != S_GAP) || gap_tc),
        .inc (state == S_GAP),
        .cnt (gap_cnt), .tc (gap_tc)
    );

    // Counts consecutive symbol-free DRAIN cycles.
    burst_counter #(.W(TW), .TERM(TIMEOUT_CYC - 1)) u_to (
        .clk (clk), .rst (rst),
        .clr (!in_drain || bus.sym_valid),
        .inc (in_drain && !bus.sym_valid),
        .cnt (to_cnt), .tc (to_tc)
    );

    logic unused_cnts;
    assign unused_cnts = ^{bit_cnt, sym_cnt, gap_cnt, to_cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            nb_q       <= '0;
            blk_cnt    <= '0;
            busy       <= 1'b0;
            block_done <= 1'b0;
            burst_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            block_done <= 1'b0;
            burst_done <= 1'b0;
            err        <= (err && !start_acc) || sym_err || to_fire;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_blocks == 8'd0) begin
                            state      <= S_DONE;
                            burst_done <= 1'b1;
                        end else begin
                            nb_q    <= num_blocks;
                            blk_cnt <= '0;
                            busy    <= 1'b1;
                            state   <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (xfer && bit_tc) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (sym_tc) begin
                        block_done <= 1'b1;
                        blk_cnt    <= blk_cnt + 8'd1;
                        if (blk_cnt + 8'd1 == nb_q) begin
                            state      <= S_DONE;
                            burst_done <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            state <= S_GAP;
                        end
                    end else if (to_fire) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (gap_tc) begin
                        state <= S_LOAD;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
